// File: rtl/dreg_pkg.sv
// Shared defaults and the occupancy-width helper for the dreg pipeline.
package dreg_pkg;

    localparam int unsigned DREG_WIDTH_DEF = 8;
    localparam int unsigned DREG_DEPTH_DEF = 4;

    // Ceiling log2; callers pass DEPTH+1 so the result is always at least 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dreg_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
module dreg_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    // Reset/flush clear data and valid; otherwise load when enabled, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            qv <= 1'b0;
        end else if (flush) begin
            q  <= '0;
            qv <= 1'b0;
        end else if (en) begin
            q  <= d;
            qv <= dv;
        end
    end

endmodule

// File: rtl/dreg_pipe.sv
// Enabled, flushable data pipeline of DEPTH dreg_stage registers with a
// running count of valid stages. Define DREG_PIPE_QB_EN to add the Qb port
// (bitwise complement of Q).
module dreg_pipe
    import dreg_pkg::*;
#(
    parameter int unsigned WIDTH = DREG_WIDTH_DEF,
    parameter int unsigned DEPTH = DREG_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            En,
    input  logic                            flush,
    input  logic [WIDTH-1:0]                D,
    input  logic                            Dv,
    output logic [WIDTH-1:0]                Q,
    output logic                            Qv,
    output logic [clog2(DEPTH + 1)-1:0]     occ
`ifdef DREG_PIPE_QB_EN
    ,
    output logic [WIDTH-1:0]                Qb
`endif
);

    localparam int unsigned OccW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] data  [DEPTH];
    logic             valid [DEPTH];
    logic [OccW-1:0]  occ_q, occ_d;

    // Chain of stages: stage 0 takes D/Dv, stage i takes stage i-1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             dv_in;

        if (i == 0) begin : g_first
            assign d_in  = D;
            assign dv_in = Dv;
        end else begin : g_rest
            assign d_in  = data[i-1];
            assign dv_in = valid[i-1];
        end

        dreg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (En),
            .flush (flush),
            .d     (d_in),
            .dv    (dv_in),
            .q     (data[i]),
            .qv    (valid[i])
        );
    end

    // Occupancy next state: one in with Dv, one out with the last valid bit.
    // When full, an incoming valid always pairs with an outgoing one, so the
    // modular sum never leaves 0..DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (En) begin
            occ_d = occ_q + OccW'(Dv) - OccW'(valid[DEPTH-1]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign Q   = data[DEPTH-1];
    assign Qv  = valid[DEPTH-1];
    assign occ = occ_q;

`ifdef DREG_PIPE_QB_EN
    assign Qb = ~data[DEPTH-1];
`endif

endmodule

// File: tb/tb_dreg_pipe.sv
// Bench for dreg_pipe: a DEPTH=4 and a DEPTH=1 instance share one stimulus
// stream; expectations come from a history of accepted words.
module tb_dreg_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       dv;

    logic [7:0] q4, q1;
    logic       qv4, qv1;
    logic [2:0] occ4;
    logic       occ1;
`ifdef DREG_PIPE_QB_EN
    logic [7:0] qb4, qb1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } word_t;

    // Words accepted since the last reset/flush, newest at the back.
    word_t hist[$];

    dreg_pipe #(
        .WIDTH (8),
        .DEPTH (4)
    ) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .En    (en),
        .flush (flush),
        .D     (d),
        .Dv    (dv),
        .Q     (q4),
        .Qv    (qv4),
        .occ   (occ4)
`ifdef DREG_PIPE_QB_EN
        ,
        .Qb    (qb4)
`endif
    );

    dreg_pipe #(
        .WIDTH (8),
        .DEPTH (1)
    ) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .En    (en),
        .flush (flush),
        .D     (d),
        .Dv    (dv),
        .Q     (q1),
        .Qv    (qv1),
        .occ   (occ1)
`ifdef DREG_PIPE_QB_EN
        ,
        .Qb    (qb1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A depth-dd pipe shows the word accepted dd enables ago; occ counts the
    // valid words among the last dd accepted.
    task automatic expect_for(input int dd, output logic [7:0] eq, output logic ev,
                              output int eo);
        int n;
        n  = hist.size();
        eq = 8'h00;
        ev = 1'b0;
        eo = 0;
        if (n >= dd) begin
            eq = hist[n-dd].data;
            ev = hist[n-dd].valid;
        end
        for (int k = 0; k < dd && k < n; k++) begin
            if (hist[n-1-k].valid) eo++;
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] eq;
        logic       ev;
        int         eo;
        expect_for(4, eq, ev, eo);
        cmp({tag, "/q4"},   {24'h0, q4},   {24'h0, eq});
        cmp({tag, "/qv4"},  {31'h0, qv4},  {31'h0, ev});
        cmp({tag, "/occ4"}, {29'h0, occ4}, eo);
`ifdef DREG_PIPE_QB_EN
        cmp({tag, "/qb4"},  {24'h0, qb4},  {24'h0, ~eq});
`endif
        expect_for(1, eq, ev, eo);
        cmp({tag, "/q1"},   {24'h0, q1},   {24'h0, eq});
        cmp({tag, "/qv1"},  {31'h0, qv1},  {31'h0, ev});
        cmp({tag, "/occ1"}, {31'h0, occ1}, eo);
`ifdef DREG_PIPE_QB_EN
        cmp({tag, "/qb1"},  {24'h0, qb1},  {24'h0, ~eq});
`endif
    endtask

    // Present inputs, take one rising edge, update the history, then check.
    task automatic step(input logic e, input logic f, input logic [7:0] dd, input logic v,
                        input string tag);
        en    = e;
        flush = f;
        d     = dd;
        dv    = v;
        @(posedge clk);
        #1;
        if (f) begin
            hist.delete();
        end else if (e) begin
            hist.push_back('{data: dd, valid: v});
            if (hist.size() > 4) void'(hist.pop_front());
        end
        check(tag);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        flush = 1'b0;
        d     = 8'h00;
        dv    = 1'b0;
        #3;
        check("reset");
        cmp("reset_q4", {24'h0, q4}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Latency: A5 first, then three more valid words.
        step(1'b1, 1'b0, 8'hA5, 1'b1, "lat0");
        cmp("lat_d1_q", {24'h0, q1}, 32'hA5);
        cmp("lat_occ1", {29'h0, occ4}, 32'd1);
        step(1'b1, 1'b0, 8'h11, 1'b1, "lat1");
        cmp("lat_occ2", {29'h0, occ4}, 32'd2);
        step(1'b1, 1'b0, 8'h22, 1'b1, "lat2");
        cmp("lat_occ3", {29'h0, occ4}, 32'd3);
        cmp("lat_early_qv", {31'h0, qv4}, 32'd0);
        step(1'b1, 1'b0, 8'h33, 1'b1, "lat3");
        cmp("lat_occ4", {29'h0, occ4}, 32'd4);
        cmp("lat_q", {24'h0, q4}, 32'hA5);
        cmp("lat_qv", {31'h0, qv4}, 32'd1);

        // Stall: stream 01..04, hold for three cycles, then drain.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b1, "stream");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'($urandom), 1'($urandom), "stall");
            cmp("stall_q", {24'h0, q4}, 32'h01);
            cmp("stall_occ", {29'h0, occ4}, 32'd4);
        end
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, "drain");
            cmp("drain_q", {24'h0, q4}, i);
            cmp("drain_qv", {31'h0, qv4}, 32'd1);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, "drain_end");
        cmp("empty_occ", {29'h0, occ4}, 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0, "empty_hold");

        // Asynchronous reset mid-cycle with three words in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h50 + 8'(i), 1'b1, "fill3");
        cmp("pre_rst_occ", {29'h0, occ4}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        hist.delete();
        check("rst_mid");
        cmp("rst_mid_occ", {29'h0, occ4}, 32'd0);
        #1;
        rst = 1'b0;

        // Flush with En: the word presented with flush is discarded.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b1, "fill4");
        cmp("pre_flush_occ", {29'h0, occ4}, 32'd4);
        step(1'b1, 1'b1, 8'h77, 1'b1, "flush");
        cmp("flush_occ", {29'h0, occ4}, 32'd0);
        cmp("flush_qv", {31'h0, qv4}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, "post_flush");
            cmp("no_77", {31'h0, q4 == 8'h77}, 32'd0);
        end

        // Full steady state.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom), 1'b1, "fill_full");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 1'b1, "full");
            cmp("full_occ", {29'h0, occ4}, 32'd4);
            cmp("full_qv", {31'h0, qv4}, 32'd1);
        end

        // Random mix of enable, flush, data and valid.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 8'($urandom), 1'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dreg_pipe.md
DREG_PIPE -- requirements
Module: dreg_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning the data bit width per stage (legal range 1 or more).
REQ-002 The block SHALL expose parameter DEPTH, default 4, meaning the number of register stages (legal range 1 or more).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports are clk (input, 1 bit, rising-edge clock) and rst (input, 1 bit, asynchronous active-high reset).
REQ-004 The block SHALL have port En, input, 1 bit: advance enable; 0 = all stages hold.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous invalidate of all stages.
REQ-006 The block SHALL have port D, input, WIDTH bits: data into stage 0.
REQ-007 The block SHALL have port Dv, input, 1 bit: valid qualifier for D.
REQ-008 The block SHALL have port Q, output, WIDTH bits: data of the last stage (DEPTH-1).
REQ-009 The block SHALL have port Qv, output, 1 bit: valid bit of the last stage.
REQ-010 The block SHALL have port occ, output, clog2(DEPTH+1) bits: count of valid stages.
REQ-011 The block SHALL have port Qb, output, WIDTH bits: bitwise complement of Q; this port is present only under the macro in REQ-024.

Function
REQ-012 On each rising clk edge with rst=0, flush=0 and En=1, the block SHALL load stage 0 data and valid from D and Dv, and stage i from stage i-1 for i = 1..DEPTH-1.
REQ-013 With En=0 and flush=0, every stage's data and valid, and occ, SHALL hold.
REQ-014 With flush=1, the block SHALL clear all valid bits to 0, all stage data to 0 and occ to 0 on the next edge, regardless of En; the D/Dv presented in that cycle SHALL be discarded.
REQ-015 Latency: with En held at 1, a word presented on D SHALL appear on Q/Qv exactly DEPTH rising edges later; each cycle with En=0 SHALL add one cycle of latency.
REQ-016 Q and Qv SHALL be driven directly from the last stage's registers, with no combinational path from D, Dv or En.
REQ-017 occ SHALL be a registered counter updated on each En=1 edge as occ + Dv - (valid of stage DEPTH-1), and SHALL always equal the number of set valid bits.
REQ-018 Boundary: when occ = DEPTH and an edge has En=1, Dv=1 and the last stage valid, occ SHALL stay at DEPTH; no overflow or saturation logic is permitted beyond REQ-017.
REQ-019 Boundary: when occ = 0 and an edge has En=1 and Dv=0, occ SHALL stay at 0.
REQ-020 Invalid words (Dv=0) SHALL still shift their data bits; consumers qualify Q with Qv.
REQ-021 With DEPTH=1, the block SHALL behave as a single enabled D register with valid bit, and occ SHALL be 1 bit wide.

Reset
REQ-022 Asserting rst SHALL immediately, without waiting for clk, force all stage data, valid bits, Q, Qv and occ to 0 (and Qb to all-ones when present).
REQ-023 rst SHALL have priority over flush and En; the first edge after rst deasserts SHALL obey REQ-012 to REQ-014 normally, and a reset mid-stream SHALL lose all in-flight words.

Configuration
REQ-024 With macro DREG_PIPE_QB_EN defined, the block SHALL include port Qb equal to ~Q combinationally from the last-stage register; with it undefined, the block SHALL have no Qb port and no Qb logic, and all other behaviour SHALL be identical.

Structure
REQ-025 A shared package dreg_pkg SHALL hold the default constants DREG_WIDTH_DEF = 8 and DREG_DEPTH_DEF = 4, plus an occ-width helper function clog2.
REQ-026 One sub-module, dreg_stage, SHALL be used: a single WIDTH-bit data plus valid register with rst, En and flush, instantiated DEPTH times via a generate loop; the occ counter SHALL reside in dreg_pipe.

Verification
REQ-027 Reset: assert rst mid-cycle with occ = 3 -> Q = 0, Qv = 0 and occ = 0 immediately (Qb = 8'hFF when enabled), before the next clk edge.
REQ-028 Latency (WIDTH=8, DEPTH=4, En=1): D = 8'hA5 with Dv=1 at edge 0 -> Q = 8'hA5 and Qv = 1 after edge 4; occ runs 1, 2, 3, 4.
REQ-029 Stall: stream 8'h01 to 8'h04, then drop En for 3 cycles -> Q, Qv and occ frozen; after En returns, the words emerge in order 8'h01 to 8'h04 with no loss or duplication.
REQ-030 Flush with En: occ = 4 and flush=1, En=1, D = 8'h77, Dv=1 -> next cycle occ = 0, Qv = 0, and 8'h77 never appears on Q.
REQ-031 Full steady state: occ = 4 with En=1 and Dv=1 every cycle for 10 cycles -> occ stays 4 and Qv stays 1 throughout.
REQ-032 Build the bench both with and without DREG_PIPE_QB_EN at DEPTH=1 and DEPTH=4 -> Qb = ~Q when enabled, the bench elaborates without Qb when disabled, and DEPTH=1 shows a 1-cycle latency.
